// File: rtl/fsm_in_debounce.sv
// Two-channel input conditioner: 2-flop synchroniser plus debounce FSM per channel.
// A channel's output flips only after its new level has held for DB_COUNT cycles.
module fsm_in_debounce #(
    parameter int unsigned DB_COUNT = 50000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw1,
    input  logic raw2,
    output logic in1,
    output logic in2,
    output logic chg,
    output logic glitch
);

    typedef enum logic [1:0] {
        StStable0 = 2'b00,
        StWait1   = 2'b01,
        StStable1 = 2'b10,
        StWait0   = 2'b11
    } db_state_e;

    localparam logic [CNT_W-1:0] CntMax  = CNT_W'(DB_COUNT - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntZero = '0;

    logic [1:0]       raw;
    logic [1:0]       q1;
    logic [1:0]       s;
    db_state_e        state [2];
    logic [CNT_W-1:0] cnt   [2];
    logic [1:0]       dout;
    logic [1:0]       qual;
    logic [1:0]       abort;

    assign raw = {raw2, raw1};
    assign in1 = dout[0];
    assign in2 = dout[1];

    // Plain flop chain, no logic in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= 2'b00;
            s  <= 2'b00;
        end else begin
            q1 <= raw;
            s  <= q1;
        end
    end

    // Qualify / abort decode per channel, shared by the FSM and the strobes.
    always_comb begin
        qual  = 2'b00;
        abort = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            unique case (state[ch])
                StWait1: begin
                    abort[ch] = ~s[ch];
                    qual[ch]  = s[ch] && (cnt[ch] == CntMax);
                end
                StWait0: begin
                    abort[ch] = s[ch];
                    qual[ch]  = ~s[ch] && (cnt[ch] == CntMax);
                end
                default: begin
                    abort[ch] = 1'b0;
                    qual[ch]  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < 2; ch++) begin
                state[ch] <= StStable0;
                cnt[ch]   <= CntZero;
            end
            dout   <= 2'b00;
            chg    <= 1'b0;
            glitch <= 1'b0;
        end else begin
            chg    <= |qual;
            glitch <= |abort;
            for (int ch = 0; ch < 2; ch++) begin
                case (state[ch])
                    StStable0: begin
                        if (s[ch]) begin
                            state[ch] <= StWait1;
                            cnt[ch]   <= CntZero;
                        end
                    end
                    StWait1: begin
                        if (!s[ch]) begin
                            state[ch] <= StStable0;
                            cnt[ch]   <= CntZero;
                        end else if (cnt[ch] == CntMax) begin
                            state[ch] <= StStable1;
                            cnt[ch]   <= CntZero;
                            dout[ch]  <= 1'b1;
                        end else begin
                            cnt[ch] <= cnt[ch] + CntOne;
                        end
                    end
                    StStable1: begin
                        if (!s[ch]) begin
                            state[ch] <= StWait0;
                            cnt[ch]   <= CntZero;
                        end
                    end
                    StWait0: begin
                        if (s[ch]) begin
                            state[ch] <= StStable1;
                            cnt[ch]   <= CntZero;
                        end else if (cnt[ch] == CntMax) begin
                            state[ch] <= StStable0;
                            cnt[ch]   <= CntZero;
                            dout[ch]  <= 1'b0;
                        end else begin
                            cnt[ch] <= cnt[ch] + CntOne;
                        end
                    end
                    default: begin
                        state[ch] <= StStable0;
                        cnt[ch]   <= CntZero;
                        dout[ch]  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fsm_in_debounce.sv
// Directed bench for fsm_in_debounce with DB_COUNT=4; expected output vectors
// {in1,in2,chg,glitch} are queued per edge and checked 1 time unit after that edge.
module tb_fsm_in_debounce;

    logic clk = 1'b0;
    logic rst;
    logic raw1;
    logic raw2;
    logic in1;
    logic in2;
    logic chg;
    logic glitch;

    fsm_in_debounce #(
        .DB_COUNT(4),
        .CNT_W   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .raw1  (raw1),
        .raw2  (raw2),
        .in1   (in1),
        .in2   (in2),
        .chg   (chg),
        .glitch(glitch)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] vec;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    int   base;

    task automatic expect_at(input int e, input logic [3:0] v, input string tag);
        exp_t x;
        x.cyc = e;
        x.vec = v;
        x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic expect_range(input int from, input int to, input logic [3:0] v,
                                input string tag);
        for (int e = from; e <= to; e++) expect_at(e, v, tag);
    endtask

    task automatic check_due();
        logic [3:0] obs;
        obs = {in1, in2, chg, glitch};
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                tests++;
                assert (obs === sb[i].vec) else begin
                    fails++;
                    $error("FAIL %s edge=%0d observed in1,in2,chg,glitch=%b expected=%b",
                           sb[i].tag, cyc, obs, sb[i].vec);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                tests++;
                fails++;
                $error("FAIL %s edge=%0d never checked, observed=%b expected=%b",
                       sb[i].tag, sb[i].cyc, obs, sb[i].vec);
                sb.delete(i);
            end
        end
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            check_due();
        end
    endtask

    initial begin
        // 1: reset held with both raw inputs high
        rst  = 1'b1;
        raw1 = 1'b1;
        raw2 = 1'b1;
        expect_range(1, 3, 4'b0000, "rst_hold");
        hold(3);
        rst  = 1'b0;
        base = cyc + 1;
        expect_range(base, base + 5, 4'b0000, "rst_release_wait");
        expect_at(base + 6, 4'b1110, "rst_release_rise");
        expect_at(base + 7, 4'b1100, "rst_release_chg_once");
        hold(8);

        // both fall together
        raw1 = 1'b0;
        raw2 = 1'b0;
        base = cyc + 1;
        expect_range(base, base + 5, 4'b1100, "fall_both_wait");
        expect_at(base + 6, 4'b0010, "fall_both");
        expect_at(base + 7, 4'b0000, "fall_both_chg_once");
        hold(8);

        // 2: clean rise on channel 1
        raw1 = 1'b1;
        base = cyc + 1;
        expect_range(base, base + 5, 4'b0000, "clean_wait");
        expect_at(base + 6, 4'b1010, "clean_rise");
        expect_range(base + 7, base + 9, 4'b1000, "clean_hold");
        hold(10);

        // 6a: 3-cycle low pulse from in1=1 is rejected
        raw1 = 1'b0;
        base = cyc + 1;
        expect_range(base, base + 4, 4'b1000, "short_pulse_wait");
        expect_at(base + 5, 4'b1001, "short_pulse_glitch");
        expect_range(base + 6, base + 9, 4'b1000, "short_pulse_hold");
        hold(3);
        raw1 = 1'b1;
        hold(7);

        // 6b: long low accepted
        raw1 = 1'b0;
        base = cyc + 1;
        expect_range(base, base + 5, 4'b1000, "fall_wait");
        expect_at(base + 6, 4'b0010, "fall");
        expect_range(base + 7, base + 9, 4'b0000, "fall_hold");
        hold(10);

        // 3: bounce 1,1,0,1,1,...
        raw1 = 1'b1;
        base = cyc + 1;
        expect_range(base, base + 3, 4'b0000, "bounce_pre");
        expect_at(base + 4, 4'b0001, "bounce_glitch");
        expect_range(base + 5, base + 8, 4'b0000, "bounce_wait");
        expect_at(base + 9, 4'b1010, "bounce_rise");
        expect_at(base + 10, 4'b1000, "bounce_hold");
        hold(2);
        raw1 = 1'b0;
        hold(1);
        raw1 = 1'b1;
        hold(8);

        raw1 = 1'b0;
        base = cyc + 1;
        expect_range(base, base + 5, 4'b1000, "bounce_fall_wait");
        expect_at(base + 6, 4'b0010, "bounce_fall");
        expect_at(base + 7, 4'b0000, "bounce_fall_idle");
        hold(8);

        // 4: simultaneous rise
        raw1 = 1'b1;
        raw2 = 1'b1;
        base = cyc + 1;
        expect_range(base, base + 5, 4'b0000, "simul_wait");
        expect_at(base + 6, 4'b1110, "simul_rise");
        expect_at(base + 7, 4'b1100, "simul_chg_once");
        hold(8);

        raw1 = 1'b0;
        raw2 = 1'b0;
        base = cyc + 1;
        expect_range(base, base + 5, 4'b1100, "simul_fall_wait");
        expect_at(base + 6, 4'b0010, "simul_fall");
        expect_at(base + 7, 4'b0000, "simul_fall_idle");
        hold(8);

        // 5: reset pulse while channel 2 counts (cnt=2)
        raw2 = 1'b1;
        base = cyc + 1;
        expect_range(base, base + 4, 4'b0000, "midrst_count");
        expect_at(base + 5, 4'b0000, "midrst_reset");
        expect_range(base + 6, base + 11, 4'b0000, "midrst_requal");
        expect_at(base + 12, 4'b0110, "midrst_rise");
        expect_at(base + 13, 4'b0100, "midrst_hold");
        hold(5);
        rst = 1'b1;
        hold(1);
        rst = 1'b0;
        hold(8);

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_drain observed=%0d pending expected=0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
